// File: rtl/jump_arc_ctrl.sv
// Jump-height generator for the player sprite: rise, optional apex hold, fall.
// Motion advances only on frame ticks; air re-jumps are limited to MAX_JUMPS.
module jump_arc_ctrl #(
  parameter int WIDTH     = 10,
  parameter int STEP      = 15,
  parameter int PEAK      = 90,
  parameter int CEIL      = 500,
  parameter int HOLD      = 2,
  parameter int MAX_JUMPS = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           tick,
  input  logic                           jump_req,
  output logic [WIDTH-1:0]               height,
  output logic                           airborne,
  output logic                           at_peak,
  output logic                           land,
  output logic [$clog2(MAX_JUMPS+1)-1:0] jumps_used
);

  localparam int JW  = $clog2(MAX_JUMPS+1);
  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;

  // Wide constants so sums can be compared without wrapping.
  localparam logic [WIDTH:0]   STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   PEAK_X    = (WIDTH+1)'(PEAK);
  localparam logic [WIDTH:0]   CEIL_X    = (WIDTH+1)'(CEIL);
  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] CEIL_W    = WIDTH'(CEIL);
  localparam logic [WIDTH-1:0] APEX0_W   = WIDTH'((PEAK < CEIL) ? PEAK : CEIL);
  localparam logic [HCW-1:0]   HOLD_LAST = HCW'((HOLD > 0) ? HOLD - 1 : 0);
  localparam logic [JW-1:0]    MAX_J     = JW'(MAX_JUMPS);
  localparam logic [JW-1:0]    ONE_J     = JW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    HOLDS = 2'd2,
    FALL = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] height_next;
  logic [WIDTH-1:0] apex, apex_next;
  logic [HCW-1:0]   hold_cnt, hold_cnt_next;
  logic [JW-1:0]    jumps_next;
  logic             land_next;
  logic             req_q;

  logic             jedge;
  logic             can_rejump;
  logic [WIDTH:0]   rise_sum;
  logic [WIDTH-1:0] rise_h;
  logic [WIDTH:0]   rejump_sum;
  logic [WIDTH-1:0] rejump_apex;

  assign jedge      = jump_req & ~req_q;
  assign can_rejump = jedge && (jumps_used < MAX_J);

  // Saturating rise step and clamped re-jump apex, computed one bit wider.
  assign rise_sum    = {1'b0, height} + STEP_X;
  assign rise_h      = (rise_sum >= {1'b0, apex}) ? apex : rise_sum[WIDTH-1:0];
  assign rejump_sum  = {1'b0, height} + PEAK_X;
  assign rejump_apex = (rejump_sum > CEIL_X) ? CEIL_W : rejump_sum[WIDTH-1:0];

  assign airborne = (state != IDLE);
  assign at_peak  = (state == HOLDS);

  // State and datapath registers; req_q resets high so a held button cannot jump.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      height     <= '0;
      apex       <= '0;
      hold_cnt   <= '0;
      jumps_used <= '0;
      land       <= 1'b0;
      req_q      <= 1'b1;
    end else begin
      state      <= state_next;
      height     <= height_next;
      apex       <= apex_next;
      hold_cnt   <= hold_cnt_next;
      jumps_used <= jumps_next;
      land       <= land_next;
      req_q      <= jump_req;
    end
  end

  // Next-state logic: a usable jump edge outranks the frame tick.
  always_comb begin
    state_next    = state;
    height_next   = height;
    apex_next     = apex;
    hold_cnt_next = hold_cnt;
    jumps_next    = jumps_used;
    land_next     = 1'b0;

    if (state == IDLE) begin
      if (jedge) begin
        state_next = RISE;
        apex_next  = APEX0_W;
        jumps_next = ONE_J;
      end
    end else if (can_rejump) begin
      state_next = RISE;
      apex_next  = rejump_apex;
      jumps_next = jumps_used + ONE_J;
    end else if (tick) begin
      case (state)
        RISE: begin
          height_next = rise_h;
          if (rise_h == apex) begin
            hold_cnt_next = '0;
            state_next    = (HOLD > 0) ? HOLDS : FALL;
          end
        end
        HOLDS: begin
          if (hold_cnt == HOLD_LAST) begin
            state_next = FALL;
          end else begin
            hold_cnt_next = hold_cnt + HCW'(1);
          end
        end
        FALL: begin
          if ({1'b0, height} <= STEP_X) begin
            height_next = '0;
            state_next  = IDLE;
            land_next   = 1'b1;
            jumps_next  = '0;
          end else begin
            height_next = height - STEP_W;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jump_arc_ctrl.sv
// Directed bench for jump_arc_ctrl: default instance plus a PEAK=100 instance.
module tb_jump_arc_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       jump_req;

  logic [9:0] height, height1;
  logic       airborne, airborne1;
  logic       at_peak, at_peak1;
  logic       land, land1;
  logic [1:0] jumps_used, jumps_used1;

  int tests  = 0;
  int failed = 0;

  jump_arc_ctrl u0 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .jump_req(jump_req),
    .height(height), .airborne(airborne), .at_peak(at_peak),
    .land(land), .jumps_used(jumps_used)
  );

  jump_arc_ctrl #(.PEAK(100)) u1 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .jump_req(jump_req),
    .height(height1), .airborne(airborne1), .at_peak(at_peak1),
    .land(land1), .jumps_used(jumps_used1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Tick once every 4 clocks.
  task automatic do_tick();
    tick1();
    repeat (3) step();
  endtask

  task automatic press();
    jump_req = 1'b1;
    step();
    jump_req = 1'b0;
    step();
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n  = 1'b0;
    tick     = 1'b0;
    jump_req = 1'b0;
    step();
    step();
    chk("rst_height", height, 0);
    chk("rst_airborne", airborne, 0);
    chk("rst_at_peak", at_peak, 0);
    chk("rst_land", land, 0);
    chk("rst_jumps", jumps_used, 0);
    reset_n = 1'b1;
    step();

    // 1: full default arc
    jump_req = 1'b1;
    step();
    chk("t1_launch_air", airborne, 1);
    chk("t1_launch_jumps", jumps_used, 1);
    chk("t1_launch_h", height, 0);
    jump_req = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      do_tick();
      chk($sformatf("t1_rise%0d", i), height, 15 * i);
    end
    chk("t1_peak_a", at_peak, 1);
    do_tick();
    chk("t1_peak_b", at_peak, 1);
    chk("t1_peak_h", height, 90);
    do_tick();
    chk("t1_fall_start_peak", at_peak, 0);
    chk("t1_fall_start_h", height, 90);
    for (int i = 1; i <= 5; i++) begin
      do_tick();
      chk($sformatf("t1_fall%0d", i), height, 90 - 15 * i);
    end
    tick1();
    chk("t1_land_h", height, 0);
    chk("t1_land_pulse", land, 1);
    chk("t1_land_air", airborne, 0);
    chk("t1_land_jumps", jumps_used, 0);
    step();
    chk("t1_land_clear", land, 0);

    // 2: held button gives exactly one jump; held through reset gives none
    jump_req = 1'b1;
    step();
    chk("t2_jump", jumps_used, 1);
    for (int i = 0; i < 14; i++) do_tick();
    repeat (40) step();
    chk("t2_held_air", airborne, 0);
    chk("t2_held_h", height, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("t2_rst_held_air", airborne, 0);
    jump_req = 1'b0;
    step();

    // 3: re-jump at 45, third edge ignored
    press();
    for (int i = 0; i < 3; i++) do_tick();
    chk("t3_h45", height, 45);
    jump_req = 1'b1;
    step();
    chk("t3_rejump_jumps", jumps_used, 2);
    chk("t3_rejump_h", height, 45);
    jump_req = 1'b0;
    step();
    do_tick();
    chk("t3_h60", height, 60);
    press();
    chk("t3_third_ignored", jumps_used, 2);
    chk("t3_third_h", height, 60);
    for (int i = 1; i <= 5; i++) begin
      do_tick();
      chk($sformatf("t3_rise%0d", i), height, 60 + 15 * i);
    end
    chk("t3_peak", at_peak, 1);
    do_tick();
    do_tick();
    chk("t3_hold_done", at_peak, 0);
    for (int i = 1; i <= 8; i++) begin
      do_tick();
      chk($sformatf("t3_fall%0d", i), height, 135 - 15 * i);
    end
    tick1();
    chk("t3_land_h", height, 0);
    chk("t3_land_pulse", land, 1);
    chk("t3_land_jumps", jumps_used, 0);
    step();

    // 4: PEAK=100 instance, partial last rise step
    pulse_reset();
    press();
    chk("t4_air", airborne1, 1);
    for (int i = 1; i <= 6; i++) begin
      do_tick();
      chk($sformatf("t4_rise%0d", i), height1, 15 * i);
    end
    do_tick();
    chk("t4_sat", height1, 100);
    chk("t4_peak", at_peak1, 1);
    do_tick();
    do_tick();
    for (int i = 1; i <= 6; i++) begin
      do_tick();
      chk($sformatf("t4_fall%0d", i), height1, 100 - 15 * i);
    end
    tick1();
    chk("t4_land_h", height1, 0);
    chk("t4_land_pulse", land1, 1);
    step();
    chk("t4_land_clear", land1, 0);

    // 5: edge and tick together at height 15 in FALL
    pulse_reset();
    press();
    for (int i = 0; i < 13; i++) do_tick();
    chk("t5_h15_a", height, 15);
    jump_req = 1'b1;
    tick     = 1'b1;
    step();
    chk("t5a_h", height, 15);
    chk("t5a_land", land, 0);
    chk("t5a_air", airborne, 1);
    chk("t5a_jumps", jumps_used, 2);
    jump_req = 1'b0;
    tick     = 1'b0;
    step();
    for (int i = 0; i < 14; i++) do_tick();
    chk("t5_h15_b", height, 15);
    jump_req = 1'b1;
    tick     = 1'b1;
    step();
    chk("t5b_h", height, 0);
    chk("t5b_land", land, 1);
    chk("t5b_air", airborne, 0);
    chk("t5b_jumps", jumps_used, 0);
    jump_req = 1'b0;
    tick     = 1'b0;
    step();

    // 6: asynchronous reset mid-fall
    press();
    for (int i = 0; i < 10; i++) do_tick();
    chk("t6_h60", height, 60);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_h", height, 0);
    chk("t6_rst_air", airborne, 0);
    chk("t6_rst_land", land, 0);
    chk("t6_rst_jumps", jumps_used, 0);
    step();
    chk("t6_rst_land_after", land, 0);
    reset_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
